// File: rtl/wb_slave_mem_ws_pkg.sv
// Shared types and limits for the wait-state WISHBONE slave memory.
package wb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ACK,
        ERR,
        RTY
    } resp_e;

    localparam int unsigned WAIT_MAX = 15;

endpackage

// File: rtl/wb_slave_mem_ws_if.sv
// WISHBONE classic slave-port signal bundle.
interface wb_slave_mem_ws_if #(
    parameter int DW = 32
);
    logic [31:0]     adr;
    logic [DW-1:0]   din;
    logic            cyc;
    logic            stb;
    logic [DW/8-1:0] sel;
    logic            we;
    logic [DW-1:0]   dout;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output adr, din, cyc, stb, sel, we,
        input  dout, ack, err, rty
    );

    modport slave (
        input  adr, din, cyc, stb, sel, we,
        output dout, ack, err, rty
    );
endinterface

// File: rtl/wb_slave_mem_ws_array.sv
// Byte-enabled single-port RAM: synchronous write, registered read.
module wb_mem_array #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_we,
    input  logic [DW/8-1:0] i_be,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_re,
    output logic [DW-1:0]   o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < DW/8; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/wb_slave_mem_ws.sv
// WISHBONE classic slave memory with wait states, write-protected low
// region (err) and periodic retry injection (rty).
module wb_slave_mem_ws #(
    parameter int AW        = 18,
    parameter int DW        = 32,
    parameter int WAIT      = 0,
    parameter int RO_WORDS  = 0,
    parameter int RTY_EVERY = 0
) (
    input logic               clk,
    input logic               rst,
    wb_slave_mem_ws_if.slave  bus
);
    import wb_mem_pkg::*;

    localparam int LB = $clog2(DW/8);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LD = (WAIT > 0) ? CW'(WAIT - 1) : '0;
    localparam logic [15:0]   RTY_N   = 16'(RTY_EVERY);
    localparam logic [AW:0]   RO_N    = (AW+1)'(RO_WORDS);

    state_e          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [15:0]     r_rcnt, w_rcnt_nx, w_rcnt_inc;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW/8-1:0] r_sel;
    logic [DW-1:0]   r_din;
    resp_e           r_resp, w_resp;

    logic            w_req, w_latch, w_re, w_mem_we, w_ack;
    logic [AW-1:0]   w_bus_word, w_mem_addr;
    logic [DW-1:0]   w_rdata, w_mask;
    logic            w_unused;

    assign w_req      = bus.cyc & bus.stb;
    assign w_bus_word = bus.adr[AW+LB-1:LB];
    assign w_rcnt_inc = r_rcnt + 16'd1;
    assign w_unused   = &{1'b0, bus.adr};

    // Response is fixed at acceptance; retry outranks the protection error.
    always_comb begin
        w_resp = ACK;
        if (RTY_EVERY != 0 && w_rcnt_inc == RTY_N)
            w_resp = RTY;
        else if (bus.sel == '0 || (bus.we && {1'b0, w_bus_word} < RO_N))
            w_resp = ERR;
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rcnt_nx  = r_rcnt;
        w_latch    = 1'b0;
        w_re       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    if (RTY_EVERY != 0) w_rcnt_nx = (w_resp == RTY) ? '0 : w_rcnt_inc;
                    if (WAIT > 0) begin
                        w_state_nx = wb_mem_pkg::WAIT;
                        w_cnt_nx   = WAIT_LD;
                    end else begin
                        w_state_nx = RESP;
                        w_re       = 1'b1;
                    end
                end
            end
            wb_mem_pkg::WAIT: begin
                if (!w_req) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nx = RESP;
                    w_re       = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            RESP:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_din   <= '0;
            r_resp  <= ACK;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rcnt  <= w_rcnt_nx;
            if (w_latch) begin
                r_addr <= w_bus_word;
                r_we   <= bus.we;
                r_sel  <= bus.sel;
                r_din  <= bus.din;
                r_resp <= w_resp;
            end
        end
    end

    // The read is launched from the bus address at WAIT=0, else from the latch.
    assign w_mem_addr = (r_state == IDLE) ? w_bus_word : r_addr;
    assign w_mem_we   = (r_state == RESP) && (r_resp == ACK) && r_we;

    wb_mem_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_mem_addr),
        .i_we    (w_mem_we),
        .i_be    (r_sel),
        .i_wdata (r_din),
        .i_re    (w_re),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_mask = '0;
        for (int unsigned b = 0; b < DW/8; b++) w_mask[b*8 +: 8] = {8{r_sel[b]}};
    end

    assign w_ack    = (r_state == RESP) && (r_resp == ACK);
    assign bus.ack  = w_ack;
    assign bus.err  = (r_state == RESP) && (r_resp == ERR);
    assign bus.rty  = (r_state == RESP) && (r_resp == RTY);
    assign bus.dout = (w_ack && !r_we) ? (w_rdata & w_mask) : '0;
endmodule

// File: tb/tb_wb_slave_mem_ws.sv
// Scoreboard bench: two slave configurations driven by randomized transfers.
module tb_wb_slave_mem_ws;
    localparam int AW = 8;
    localparam int NW = 256;
    localparam int R_ACK = 0, R_ERR = 1, R_RTY = 2;

    typedef struct {
        int          r;
        logic [31:0] d;
        logic [31:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] t_adr [2];
    logic [31:0] t_din [2];
    logic        t_cyc [2];
    logic        t_stb [2];
    logic        t_we  [2];
    logic [3:0]  t_sel [2];

    wb_slave_mem_ws_if #(.DW(32)) bus0 ();
    wb_slave_mem_ws_if #(.DW(32)) bus1 ();

    assign bus0.adr = t_adr[0];
    assign bus0.din = t_din[0];
    assign bus0.cyc = t_cyc[0];
    assign bus0.stb = t_stb[0];
    assign bus0.we  = t_we[0];
    assign bus0.sel = t_sel[0];
    assign bus1.adr = t_adr[1];
    assign bus1.din = t_din[1];
    assign bus1.cyc = t_cyc[1];
    assign bus1.stb = t_stb[1];
    assign bus1.we  = t_we[1];
    assign bus1.sel = t_sel[1];

    wb_slave_mem_ws #(.AW(AW), .DW(32), .WAIT(0), .RO_WORDS(16), .RTY_EVERY(3))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    wb_slave_mem_ws #(.AW(AW), .DW(32), .WAIT(3), .RO_WORDS(0), .RTY_EVERY(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model: word contents, per-byte "has been written" flags, retry counts.
    logic [31:0] m_mem   [2][NW];
    logic [3:0]  m_known [2][NW];
    int          rc [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          tests = 0;
    int          fails = 0;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] bm(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic exp_t predict(input int d, input logic [31:0] adr, input logic we,
                                     input logic [3:0] sel, input logic [31:0] din);
        exp_t e;
        int w, every, ro;
        logic [31:0] sm;
        w     = int'(adr[9:2]);
        every = (d == 0) ? 3 : 0;
        ro    = (d == 0) ? 16 : 0;
        sm    = bm(sel);
        e.r = R_ACK;
        e.d = '0;
        e.m = '1;
        if (every != 0) begin
            rc[d] = rc[d] + 1;
            if (rc[d] == every) begin
                rc[d] = 0;
                e.r = R_RTY;
            end
        end
        if (e.r != R_RTY && (sel == 4'h0 || (we && w < ro))) e.r = R_ERR;
        if (e.r == R_ACK && !we) begin
            e.d = m_mem[d][w] & sm;
            e.m = ~sm | (sm & bm(m_known[d][w]));
        end
        if (e.r == R_ACK && we) begin
            m_mem[d][w]   = (m_mem[d][w] & ~sm) | (din & sm);
            m_known[d][w] = m_known[d][w] | sel;
        end
        return e;
    endfunction

    function automatic void mon(input int d, input logic a, input logic er, input logic ry,
                                input logic [31:0] dout);
        exp_t e;
        int got, qs;
        tests++;
        if (a | er | ry) begin
            got = a ? R_ACK : (er ? R_ERR : R_RTY);
            qs  = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                fails++;
                $display("FAIL unexpected_term dut%0d: ack/err/rty=%b%b%b, required none", d, a, er, ry);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if ($countones({a, er, ry}) != 1 || got != e.r || ((dout ^ e.d) & e.m) !== 32'h0) begin
                    fails++;
                    $display("FAIL response dut%0d: ack/err/rty=%b%b%b dout=%h, required resp=%0d dout=%h (mask %h)",
                             d, a, er, ry, dout, e.r, e.d, e.m);
                end
            end
        end else if (dout !== 32'h0) begin
            fails++;
            $display("FAIL idle_dout dut%0d: dout=%h, required 0", d, dout);
        end
    endfunction

    always @(negedge clk) mon(0, bus0.ack, bus0.err, bus0.rty, bus0.dout);
    always @(negedge clk) mon(1, bus1.ack, bus1.err, bus1.rty, bus1.dout);

    task automatic xfer(input int d, input logic [31:0] adr, input logic we,
                        input logic [3:0] sel, input logic [31:0] din, input int abort_k);
        exp_t e;
        int n;
        logic term;
        @(negedge clk);
        if (abort_k == 0) begin
            e = predict(d, adr, we, sel, din);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        t_adr[d] = adr; t_we[d] = we; t_sel[d] = sel; t_din[d] = din;
        t_cyc[d] = 1'b1; t_stb[d] = 1'b1;
        @(posedge clk);
        n = 0;
        term = 1'b0;
        while (!term && n < 40) begin
            @(negedge clk);
            n++;
            term = (d == 0) ? (bus0.ack | bus0.err | bus0.rty) : (bus1.ack | bus1.err | bus1.rty);
            if (abort_k != 0 && n == abort_k) break;
        end
        t_cyc[d] = 1'b0; t_stb[d] = 1'b0;
        if (abort_k == 0) begin
            tests++;
            if (!term || n != ws(d) + 1) begin
                fails++;
                $display("FAIL latency dut%0d: %0d cycles (term=%0b), required %0d", d, n, term, ws(d) + 1);
            end
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    function automatic logic [31:0] radr(input int w);
        logic [31:0] r;
        r = $urandom;
        return {r[31:10], 8'(w), r[1:0]};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            rc[d] = 0;
            t_adr[d] = '0; t_din[d] = '0; t_we[d] = 1'b0; t_sel[d] = '0;
            t_cyc[d] = 1'b0; t_stb[d] = 1'b0;
            for (int w = 0; w < NW; w++) begin
                m_known[d][w] = 4'h0;
                m_mem[d][w]   = '0;
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // dut0: zero wait, protected low 16 words, retry every third request
        xfer(0, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 0);
        xfer(0, 32'h100, 1'b0, 4'hF, 32'h0, 0);
        xfer(0, 32'h03C, 1'b1, 4'hF, 32'h12345678, 0);
        xfer(0, 32'h03C, 1'b1, 4'hF, 32'h12345678, 0);
        xfer(0, 32'h040, 1'b1, 4'hF, 32'hCAFEF00D, 0);
        xfer(0, 32'h03C, 1'b0, 4'hF, 32'h0, 0);
        xfer(0, 32'h03C, 1'b0, 4'hF, 32'h0, 0);
        xfer(0, 32'h040, 1'b0, 4'h0, 32'h0, 0);

        // dut1: byte lanes, three wait states, abort mid-wait
        for (int w = 0; w < NW; w++) xfer(1, radr(w), 1'b1, 4'hF, $urandom, 0);
        xfer(1, 32'h080, 1'b1, 4'hF, 32'hFFFFFFFF, 0);
        xfer(1, 32'h080, 1'b1, 4'h2, 32'h11223344, 0);
        xfer(1, 32'h080, 1'b0, 4'hF, 32'h0, 0);
        xfer(1, 32'h080, 1'b0, 4'h1, 32'h0, 0);
        xfer(1, 32'h01C, 1'b1, 4'hF, 32'h5A5A5A5A, 2);
        xfer(1, 32'h01C, 1'b0, 4'hF, 32'h0, 0);

        // reset during the wait phase of a dut1 write
        @(negedge clk);
        t_adr[1] = 32'h014; t_we[1] = 1'b1; t_sel[1] = 4'hF; t_din[1] = 32'hA5A50F0F;
        t_cyc[1] = 1'b1; t_stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({bus0.ack, bus0.err, bus0.rty, bus1.ack, bus1.err, bus1.rty} !== 6'b0 ||
            bus0.dout !== 32'h0 || bus1.dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: flags=%b%b%b%b%b%b dout0=%h dout1=%h, required all 0",
                     bus0.ack, bus0.err, bus0.rty, bus1.ack, bus1.err, bus1.rty, bus0.dout, bus1.dout);
        end
        t_cyc[1] = 1'b0; t_stb[1] = 1'b0;
        rc[0] = 0;
        rc[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        xfer(1, 32'h014, 1'b0, 4'hF, 32'h0, 0);

        // back-to-back reads from a cleared retry counter: ack ack rty ack ack
        for (int i = 0; i < 5; i++) xfer(0, 32'h100, 1'b0, 4'hF, 32'h0, 0);

        for (int w = 16; w < NW; w++) xfer(0, radr(w), 1'b1, 4'hF, $urandom, 0);

        for (int i = 0; i < 250; i++) begin
            xfer(0, radr($urandom_range(0, NW - 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom, 0);
            xfer(1, radr($urandom_range(0, NW - 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
        end

        repeat (5) @(negedge clk);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL pending_responses: %0d/%0d left, required 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_slave_mem_ws.md
# wb_slave_mem_ws

Parametrised WISHBONE classic-cycle slave memory, the next generation of the single-configuration slave memory. It is attached to one slave port of `wishbone_bus_syscon_if`. It adds configurable data width and depth, programmable wait states, a write-protected low region answered with `err`, and deterministic retry injection answered with `rty`. Its primary use is exercising master error and retry paths in system-level benches.

## Interface
- `AW`, 18: word-address bits; depth is 2^AW words (18 with DW=32 gives 1 MB).
- `DW`, 32: data width in bits; must be 8, 16, 32 or 64.
- `WAIT`, 0: wait states inserted before every response; legal range 0..15.
- `RO_WORDS`, 0: words `0..RO_WORDS-1` are write-protected; 0 disables protection.
- `RTY_EVERY`, 0: every Nth accepted request is answered with `rty`; 0 disables retry injection.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset), synchronously released by the syscon.
- `adr`  in  32  byte address; bits `[AW+LB-1:LB]` select the word, where LB = log2(DW/8); all other bits are ignored.
- `din`  in  DW  write data.
- `cyc`  in  1  bus cycle active.
- `stb`  in  1  strobe; this slave is selected.
- `sel`  in  DW/8  byte enables.
- `we`  in  1  1 = write, 0 = read.
- `dout`  out  DW  read data.
- `ack`  out  1  normal termination.
- `err`  out  1  error termination.
- `rty`  out  1  retry termination.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `cyc&stb` sampled high means the request is accepted.
  - Address, `we`, `sel` and `din` are latched.
  - The response type is decided at acceptance.
  - Next state is WAIT if `WAIT>0` (wait counter loaded with WAIT-1), otherwise RESP.
- WAIT:
  - The counter decrements each cycle; the FSM moves to RESP when it reaches 0.
  - If `cyc` or `stb` is sampled low, the request is aborted: return to IDLE, no response, no write, retry counter unchanged.
- RESP: exactly one of `ack`/`err`/`rty` is high for one cycle; next state is IDLE unconditionally.
- Response priority at acceptance (first match wins):
  1. `rty`: the retry counter reaches `RTY_EVERY`; the counter then resets to 0.
  2. `err`: `sel==0`, or a write to word < `RO_WORDS`.
  3. `ack`: all other requests.
- Accepted requests increment the retry counter, except when retry injection is disabled (`RTY_EVERY==0`).
- Write side effects:
  - Memory is written only in a RESP cycle with `ack`, and only the bytes whose `sel` bit is set.
  - `err` and `rty` writes leave memory unchanged.
- `dout`:
  - Carries the addressed word, masked to enabled bytes (unselected bytes are 0), in the `ack` cycle of a read.
  - Is 0 in all other cycles, including `err`/`rty` and write acks.
- Memory contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset (`rst`=0) state: FSM = IDLE, wait counter = 0, retry counter = 0, `ack`/`err`/`rty` = 0, `dout` = 0.
- Reset asserted mid-transfer: outputs clear asynchronously and the pending write is dropped.
- Latency: the termination signal is high WAIT+1 cycles after the edge that samples `stb`.
- Throughput: minimum 2 cycles per transfer at WAIT=0, because RESP always passes through IDLE. The master must drop or advance `stb` in the cycle after it samples a termination signal.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Read-after-write to the same word in consecutive transfers returns the new data.

## Structure
- Package `wb_mem_pkg` holds:
  - `state_e` (IDLE, WAIT, RESP);
  - `resp_e` (ACK, ERR, RTY);
  - the `WAIT_MAX=15` constant.
- Sub-module `wb_mem_array` is a byte-enabled single-port RAM.
  - Parameters: AW, DW.
  - Synchronous write; registered read.
  - The read is issued in the last cycle before RESP so that data lands in RESP. At WAIT=0 this is the acceptance cycle.
- The FSM, counters and response decode stay in `wb_slave_mem_ws`.

## Test plan
- WAIT=0: write 0xDEADBEEF to 0x100 with `sel`=0xF, then read 0x100 → `ack` 1 cycle after each `stb`; read `dout`=0xDEADBEEF.
- WAIT=3: read any address → `ack` exactly 4 cycles after `stb` is sampled. Drop `stb` after 2 cycles → no termination; memory unchanged.
- `sel`=0x2 write of 0x11223344 over 0xFFFFFFFF → read back with `sel`=0xF gives 0xFFFF33FF. Read with `sel`=0x1 gives 0x000000FF.
- RO_WORDS=16:
  - write to 0x3C → `err`; the word is unchanged on read;
  - write to 0x40 → `ack`;
  - read of 0x3C → `ack`;
  - `sel`=0 read → `err`, `dout`=0.
- RTY_EVERY=3: five back-to-back reads → terminations `ack`, `ack`, `rty`, `ack`, `ack`. The retry takes priority over an RO error on the same request.
- `rst` pulled low during WAIT of a write → outputs are 0 immediately, FSM returns to IDLE, the target word is unchanged, and the retry counter is 0.
